// File: rtl/chacha_sequencer.sv
// Control sequencer for a 16-word ChaCha core: loads one block from the host,
// runs ROUNDS core rounds, then drains the permuted words back to the host.
module chacha_sequencer #(
    parameter int ROUNDS = 20,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] block_count,
    output logic [31:0]      core_data_in,
    output logic [3:0]       core_addr,
    output logic             core_write_n,
    output logic             core_round_n,
    input  logic [31:0]      core_data_out
);

    localparam int RND_W = $clog2(ROUNDS);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ROUND,
        DRAIN
    } state_t;

    state_t           state, state_next;
    logic [3:0]       idx, idx_next;
    logic [RND_W-1:0] rnd, rnd_next;
    logic             done_next;
    logic             load_hs;
    logic             drain_hs;

    assign load_hs  = (state == LOAD) && in_valid;
    assign drain_hs = (state == DRAIN) && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= 4'd0;
            rnd         <= '0;
            done        <= 1'b0;
            block_count <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
            rnd   <= rnd_next;
            done  <= done_next;
            if (done_next) begin
                block_count <= block_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = idx;
        rnd_next   = rnd;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                    idx_next   = 4'd0;
                end
            end
            LOAD: begin
                if (load_hs) begin
                    if (idx == 4'd15) begin
                        state_next = ROUND;
                        idx_next   = 4'd0;
                        rnd_next   = '0;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            ROUND: begin
                if (rnd == RND_W'(ROUNDS - 1)) begin
                    state_next = DRAIN;
                    idx_next   = 4'd0;
                    rnd_next   = '0;
                end else begin
                    rnd_next = rnd + RND_W'(1);
                end
            end
            DRAIN: begin
                if (drain_hs) begin
                    if (idx == 4'd15) begin
                        state_next = IDLE;
                        idx_next   = 4'd0;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx + 4'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // Abort overrides everything, but the handshake in this cycle still lands in the core or host.
        if (abort) begin
            state_next = IDLE;
            idx_next   = 4'd0;
            rnd_next   = '0;
            done_next  = 1'b0;
        end
    end

    assign in_ready     = (state == LOAD);
    assign out_valid    = (state == DRAIN);
    assign busy         = (state != IDLE);
    assign core_write_n = !load_hs;
    assign core_round_n = (state != ROUND);
    assign core_addr    = ((state == LOAD) || (state == DRAIN)) ? idx : 4'd0;
    assign core_data_in = (state == LOAD) ? in_data : 32'd0;
    assign out_data     = out_valid ? core_data_out : 32'd0;

endmodule

// File: tb/tb_chacha_sequencer.sv
// Bench for chacha_sequencer: a behavioural ChaCha core hangs off the core port,
// expected output words come from a reference permutation and RFC 7539 constants.
module tb_chacha_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, abort;
    logic        in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid, out_ready;
    logic [31:0] out_data;
    logic        busy, done;
    logic [15:0] block_count;
    logic [31:0] core_data_in;
    logic [3:0]  core_addr;
    logic        core_write_n, core_round_n;
    logic [31:0] core_data_out;

    int checks = 0;
    int passed = 0;

    chacha_sequencer #(.ROUNDS(20), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .block_count(block_count),
        .core_data_in(core_data_in), .core_addr(core_addr),
        .core_write_n(core_write_n), .core_round_n(core_round_n),
        .core_data_out(core_data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] qr(input logic [31:0] a_in, b_in, c_in, d_in);
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    function automatic logic [511:0] do_round(input logic [511:0] s, input logic diag);
        logic [511:0] r;
        logic [127:0] q;
        int a, b, c, d;
        r = s;
        for (int i = 0; i < 4; i++) begin
            a = i;
            b = 4 + (diag ? (i + 1) % 4 : i);
            c = 8 + (diag ? (i + 2) % 4 : i);
            d = 12 + (diag ? (i + 3) % 4 : i);
            q = qr(r[a*32 +: 32], r[b*32 +: 32], r[c*32 +: 32], r[d*32 +: 32]);
            r[a*32 +: 32] = q[127:96];
            r[b*32 +: 32] = q[95:64];
            r[c*32 +: 32] = q[63:32];
            r[d*32 +: 32] = q[31:0];
        end
        return r;
    endfunction

    function automatic logic [511:0] chacha_ref(input logic [511:0] s);
        logic [511:0] r;
        r = s;
        for (int i = 0; i < 20; i++) r = do_round(r, i[0]);
        return r;
    endfunction

    // Behavioural core: alternates column/diagonal rounds, restarting at column after a write.
    logic [511:0] core_state = '0;
    logic         core_diag = 1'b0;
    always @(posedge clk) begin
        if (!core_write_n) begin
            core_state[int'(core_addr)*32 +: 32] <= core_data_in;
            core_diag <= 1'b0;
        end else if (!core_round_n) begin
            core_state <= do_round(core_state, core_diag);
            core_diag  <= !core_diag;
        end
    end
    assign core_data_out = core_state[int'(core_addr)*32 +: 32];

    logic mon_clear = 1'b0;
    int cyc = 0, first_load = -1, first_out = -1, run = 0, last_run = 0;
    int done_cnt = 0, spurious = 0, both_low = 0;
    always @(negedge clk) begin
        if (mon_clear) begin
            cyc = 0; first_load = -1; first_out = -1; run = 0; last_run = 0;
            done_cnt = 0; spurious = 0; both_low = 0;
        end else begin
            cyc++;
            if (in_valid && in_ready && first_load < 0) first_load = cyc;
            if (out_valid && first_out < 0) first_out = cyc;
            if (!core_round_n) run++;
            else begin
                if (run > 0) last_run = run;
                run = 0;
            end
            if (done) done_cnt++;
            if (!core_write_n && !in_valid) spurious++;
            if (!core_write_n && !core_round_n) both_low++;
        end
    end

    logic [31:0] sb[$];
    logic [31:0] got_words[16];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    endtask

    typedef struct {
        logic       start;
        logic       abort;
        logic       in_valid;
        logic       exp_busy;
        logic       exp_in_ready;
        logic       exp_write_n;
        logic [3:0] exp_addr;
    } vec_t;

    task automatic applyStimulus(input vec_t v);
        start    = v.start;
        abort    = v.abort;
        in_valid = v.in_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic load_words(input logic [511:0] s, input int count, input int gap_every);
        int g;
        for (int i = 0; i < count; i++) begin
            if (gap_every > 0 && (i % gap_every) == gap_every - 1) begin
                in_valid = 1'b0;
                in_data  = 32'hbad0_0000 | i;
                repeat (2) begin @(posedge clk); #1; end
            end
            g = 0;
            while (!in_ready && g < 50) begin @(posedge clk); #1; g++; end
            if (g >= 50) checkOutput("load_wait_timeout", 32'(g), 32'd0);
            in_valid = 1'b1;
            in_data  = s[i*32 +: 32];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic load_block(input logic [511:0] s, input int gap_every);
        logic [511:0] e;
        e = chacha_ref(s);
        for (int i = 0; i < 16; i++) sb.push_back(e[i*32 +: 32]);
        load_words(s, 16, gap_every);
    endtask

    task automatic drain_block(input int stall_idx, input int stall_len, input int start_at);
        int got = 0, guard = 0, stall = 0;
        while (got < 16 && guard < 200) begin
            start = out_valid && (got == start_at);
            if (out_valid && got == stall_idx && stall < stall_len) begin
                out_ready = 1'b0;
                checkOutput("stall_hold_data", out_data, sb[0]);
                checkOutput("stall_hold_addr", 32'(core_addr), 32'(stall_idx));
                stall++;
            end else begin
                out_ready = 1'b1;
                if (out_valid) begin
                    got_words[got] = out_data;
                    checkOutput("out_word", out_data, sb.pop_front());
                    got++;
                end
            end
            @(posedge clk);
            #1;
            guard++;
        end
        out_ready = 1'b0;
        start     = 1'b0;
        if (got < 16) checkOutput("drain_timeout", 32'(got), 32'd16);
    endtask

    logic [511:0] rfc_in, rnd_in;
    vec_t vecs[8];
    int prev_count;

    initial begin
        for (int i = 0; i < 16; i++) rnd_in[i*32 +: 32] = $urandom;
        rfc_in = {32'h00000000, 32'h4a000000, 32'h09000000, 32'h00000001,
                  32'h1f1e1d1c, 32'h1b1a1918, 32'h17161514, 32'h13121110,
                  32'h0f0e0d0c, 32'h0b0a0908, 32'h07060504, 32'h03020100,
                  32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};

        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd0};
        vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        in_valid = 1'b1; in_data = 32'hdeadbeef; out_ready = 1'b1;
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_block_count", 32'(block_count), 32'd0);
        checkOutput("rst_write_n", 32'(core_write_n), 32'd1);
        checkOutput("rst_round_n", 32'(core_round_n), 32'd1);
        checkOutput("rst_core_addr", 32'(core_addr), 32'd0);
        checkOutput("rst_core_data_in", core_data_in, 32'd0);
        checkOutput("rst_out_data", out_data, 32'd0);
        in_valid = 1'b0; out_ready = 1'b0; in_data = 32'h12345678;
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_in_ready));
            checkOutput($sformatf("vec%0d_write_n", i), 32'(core_write_n), 32'(vecs[i].exp_write_n));
            checkOutput($sformatf("vec%0d_addr", i), 32'(core_addr), 32'(vecs[i].exp_addr));
        end
        start = 1'b0; abort = 1'b0; in_valid = 1'b0;

        mon_clear = 1'b1;
        @(posedge clk);
        #1;
        mon_clear = 1'b0;

        // RFC 7539 block with no host stalls
        pulse_start();
        load_block(rfc_in, 0);
        drain_block(-1, 0, -1);
        checkOutput("rfc_word0", got_words[0], 32'h837778ab);
        checkOutput("rfc_word1", got_words[1], 32'he238d763);
        checkOutput("done_after_block", 32'(done), 32'd1);
        checkOutput("count_after_block1", 32'(block_count), 32'd1);
        checkOutput("round_run_len", 32'(last_run), 32'd20);
        checkOutput("first_out_latency", 32'(first_out - first_load), 32'd36);
        pulse_start();
        checkOutput("done_start_busy", 32'(busy), 32'd1);
        checkOutput("done_single_cycle", 32'(done), 32'd0);
        checkOutput("done_cnt_block1", 32'(done_cnt), 32'd1);

        // Load gaps, start during ROUND and DRAIN, output backpressure at word 7
        load_block(rnd_in, 4);
        pulse_start();
        drain_block(7, 5, 12);
        checkOutput("count_after_block2", 32'(block_count), 32'd2);
        checkOutput("spurious_writes", 32'(spurious), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("done_cnt_block2", 32'(done_cnt), 32'd2);

        // Abort after 9 load words; the word offered in the abort cycle is still written
        prev_count = int'(block_count);
        pulse_start();
        load_words(rnd_in, 9, 0);
        in_valid = 1'b1;
        in_data  = 32'hcafef00d;
        abort    = 1'b1;
        checkOutput("abort_cycle_write_n", 32'(core_write_n), 32'd0);
        @(posedge clk);
        #1;
        abort = 1'b0; in_valid = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_addr", 32'(core_addr), 32'd0);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("abort_no_done", 32'(done_cnt), 32'd2);
        checkOutput("abort_count", 32'(block_count), 32'(prev_count));
        pulse_start();
        load_block(rfc_in, 0);
        drain_block(-1, 0, -1);
        checkOutput("rfc_after_abort_w0", got_words[0], 32'h837778ab);
        checkOutput("count_after_abort", 32'(block_count), 32'(prev_count + 1));
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        checkOutput("no_write_round_overlap", 32'(both_low), 32'd0);

        // Asynchronous reset between edges while rounds are running
        pulse_start();
        load_block(rnd_in, 0);
        repeat (3) begin @(posedge clk); #1; end
        checkOutput("mid_round_active", 32'(core_round_n), 32'd0);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_round_n", 32'(core_round_n), 32'd1);
        checkOutput("async_rst_busy", 32'(busy), 32'd0);
        checkOutput("async_rst_count", 32'(block_count), 32'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_rst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
